// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program-counter sequencer: fetch handshake, PC/link update, flush, retire count
// Optional fetch timeout built when FETCH_TIMEOUT_EN is defined.
module pc_sequencer #(
   parameter int PC_W  = 8,
   parameter int OFF_W = 8,
   parameter int TO_W  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              halt_req,
   output logic              imem_req,
   output logic [PC_W-1:0]   imem_addr,
   input  logic              imem_ack,
   input  logic [1:0]        bs,
   input  logic              ps,
   input  logic              z,
   input  logic [OFF_W-1:0]  br_offset,
   input  logic [PC_W-1:0]   jump_target,
   output logic [PC_W-1:0]   pc,
   output logic [PC_W-1:0]   link,
   output logic [1:0]        pc_sel,
   output logic              flush,
   output logic              busy,
   output logic              halted,
   output logic [15:0]       retired,
   output logic              fault
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_EXEC  = 2'd2,
      S_HALT  = 2'd3
   } state_t;

   localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

   state_t            r_state;
   logic [PC_W-1:0]   r_pc;
   logic [PC_W-1:0]   r_link;
   logic [15:0]       r_retired;
   logic              r_imem_req;
   logic              r_busy;
   logic              r_halted;
   logic              r_fault;

   logic [PC_W-1:0]   w_off_ext;
   logic [PC_W-1:0]   w_pc_inc;
   logic [1:0]        w_sel;
   logic              w_exec;
   logic              w_fetch_timeout;
   logic              w_resume_ok;

   generate
      if (OFF_W >= PC_W) begin : g_off_trunc
         assign w_off_ext = br_offset[PC_W-1:0];
      end else begin : g_off_sext
         assign w_off_ext = {{(PC_W-OFF_W){br_offset[OFF_W-1]}}, br_offset};
      end
   endgenerate

   // Same select encoding as the datapath branch logic
   assign w_sel    = {bs[1], bs[0] & (bs[1] | (ps ^ z))};
   assign w_exec   = (r_state == S_EXEC);
   assign w_pc_inc = r_pc + PC_ONE;

`ifdef FETCH_TIMEOUT_EN
   localparam logic [TO_W-1:0] TO_LAST = {{(TO_W-1){1'b1}}, 1'b0};

   logic [TO_W-1:0] r_to_cnt;

   // Last permitted wait cycle: the counter would reach all-ones on this edge
   assign w_fetch_timeout = (r_state == S_FETCH) && !imem_ack && (r_to_cnt == TO_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_to_cnt <= '0;
      end else if (r_state != S_FETCH) begin
         r_to_cnt <= '0;
      end else if (!imem_ack) begin
         r_to_cnt <= r_to_cnt + TO_W'(1);
      end
   end
`else
   assign w_fetch_timeout = 1'b0;
`endif

   assign w_resume_ok = start && !r_fault;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_pc       <= '0;
         r_link     <= '0;
         r_retired  <= '0;
         r_imem_req <= 1'b0;
         r_busy     <= 1'b0;
         r_halted   <= 1'b0;
         r_fault    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state    <= S_FETCH;
                  r_imem_req <= 1'b1;
                  r_busy     <= 1'b1;
               end
            end
            S_FETCH: begin
               if (imem_ack) begin
                  r_state    <= S_EXEC;
                  r_imem_req <= 1'b0;
               end else if (w_fetch_timeout) begin
                  r_state    <= S_HALT;
                  r_imem_req <= 1'b0;
                  r_busy     <= 1'b0;
                  r_halted   <= 1'b1;
                  r_fault    <= 1'b1;
               end
            end
            S_EXEC: begin
               case (w_sel)
                  2'b00: r_pc <= w_pc_inc;
                  2'b01: r_pc <= w_pc_inc + w_off_ext;
                  2'b10: r_pc <= jump_target;
                  default: begin
                     r_pc   <= jump_target;
                     r_link <= w_pc_inc;
                  end
               endcase
               r_retired <= r_retired + 16'd1;
               if (halt_req) begin
                  r_state  <= S_HALT;
                  r_busy   <= 1'b0;
                  r_halted <= 1'b1;
               end else begin
                  r_state    <= S_FETCH;
                  r_imem_req <= 1'b1;
               end
            end
            default: begin
               if (w_resume_ok) begin
                  r_state    <= S_FETCH;
                  r_imem_req <= 1'b1;
                  r_busy     <= 1'b1;
                  r_halted   <= 1'b0;
               end
            end
         endcase
      end
   end

   assign imem_req  = r_imem_req;
   assign imem_addr = r_pc;
   assign pc        = r_pc;
   assign link      = r_link;
   assign retired   = r_retired;
   assign busy      = r_busy;
   assign halted    = r_halted;
   assign fault     = r_fault;
   assign pc_sel    = w_exec ? w_sel : 2'b00;
   assign flush     = w_exec && (w_sel != 2'b00);

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - self-checking bench for pc_sequencer against a behavioural PC model
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        halt_req = 1'b0;
   logic        imem_req;
   logic [7:0]  imem_addr;
   logic        imem_ack = 1'b0;
   logic [1:0]  bs = 2'b00;
   logic        ps = 1'b0;
   logic        z = 1'b0;
   logic [7:0]  br_offset = 8'h00;
   logic [7:0]  jump_target = 8'h00;
   logic [7:0]  pc;
   logic [7:0]  link;
   logic [1:0]  pc_sel;
   logic        flush;
   logic        busy;
   logic        halted;
   logic [15:0] retired;
   logic        fault;

   int n_vec = 0;
   int n_err = 0;

   logic [7:0]  m_pc = 8'h00;
   logic [7:0]  m_link = 8'h00;
   logic [15:0] m_retired = 16'h0000;

   pc_sequencer #(.PC_W(8), .OFF_W(8), .TO_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .halt_req(halt_req),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
      .bs(bs), .ps(ps), .z(z), .br_offset(br_offset), .jump_target(jump_target),
      .pc(pc), .link(link), .pc_sel(pc_sel), .flush(flush), .busy(busy),
      .halted(halted), .retired(retired), .fault(fault)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Caller sits at a negedge with the DUT in IDLE or HALT
   task automatic do_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Caller sits at a negedge with the DUT in FETCH
   task automatic do_instr(input logic [1:0] b, input logic p, input logic zz,
                           input logic [7:0] off, input logic [7:0] tgt,
                           input int dly, input logic hreq);
      logic        taken;
      logic [1:0]  esel;
      logic [7:0]  nxt;
      for (int i = 0; i < dly; i++) begin
         imem_ack = 1'b0;
         check("req_wait", imem_req, 1);
         check("addr_wait", imem_addr, m_pc);
         @(negedge clk);
      end
      check("req", imem_req, 1);
      check("addr", imem_addr, m_pc);
      check("busy_fetch", busy, 1);
      imem_ack = 1'b1;
      @(negedge clk);
      imem_ack = 1'b0;
      bs = b; ps = p; z = zz; br_offset = off; jump_target = tgt; halt_req = hreq;
      #1;
      taken = (p != zz);
      nxt = m_pc + 8'd1;
      esel = 2'b00;
      case (b)
         2'b00: ;
         2'b01: if (taken) begin esel = 2'b01; nxt = m_pc + 8'd1 + off; end
         2'b10: begin esel = 2'b10; nxt = tgt; end
         default: begin esel = 2'b11; nxt = tgt; m_link = m_pc + 8'd1; end
      endcase
      check("pc_sel", pc_sel, esel);
      check("flush", flush, esel != 2'b00);
      check("req_exec", imem_req, 0);
      @(negedge clk);
      halt_req = 1'b0;
      bs = $urandom_range(0, 3);
      m_pc = nxt;
      m_retired = m_retired + 16'd1;
      check("pc", pc, m_pc);
      check("link", link, m_link);
      check("retired", retired, m_retired);
      check("halted", halted, hreq);
      check("req_next", imem_req, !hreq);
      check("flush_after", flush, 0);
      check("fault", fault, 0);
   endtask

   initial begin
      // Reset state
      #2;
      check("rst_pc", pc, 0);
      check("rst_link", link, 0);
      check("rst_retired", retired, 0);
      check("rst_req", imem_req, 0);
      check("rst_busy", busy, 0);
      check("rst_halted", halted, 0);
      check("rst_fault", fault, 0);
      check("rst_flush", flush, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_req", imem_req, 0);
      do_start();

      // Sequential run, ack every cycle
      for (int i = 0; i < 3; i++) do_instr(2'b00, 1'b0, 1'b0, 8'h00, 8'h00, 0, 1'b0);
      check("seq_retired", retired, 3);

      // Branch taken / not taken from 0x10
      do_instr(2'b10, 1'b0, 1'b0, 8'h00, 8'h10, 0, 1'b0);
      do_instr(2'b01, 1'b0, 1'b1, 8'hFC, 8'h00, 0, 1'b0);
      check("br_taken_pc", pc, 8'h0D);
      do_instr(2'b10, 1'b0, 1'b0, 8'h00, 8'h10, 0, 1'b0);
      do_instr(2'b01, 1'b0, 1'b0, 8'hFC, 8'h00, 0, 1'b0);
      check("br_not_taken_pc", pc, 8'h11);

      // Call then jump from 0x20
      do_instr(2'b10, 1'b0, 1'b0, 8'h00, 8'h20, 0, 1'b0);
      do_instr(2'b11, 1'b0, 1'b0, 8'h00, 8'h80, 0, 1'b0);
      check("call_link", link, 8'h21);
      do_instr(2'b10, 1'b0, 1'b0, 8'h00, 8'h20, 0, 1'b0);
      do_instr(2'b10, 1'b0, 1'b0, 8'h00, 8'h80, 0, 1'b0);
      check("jump_link_kept", link, 8'h21);

      // Delayed acknowledge
      do_instr(2'b00, 1'b0, 1'b0, 8'h00, 8'h00, 3, 1'b0);

      // Halt at 0x05, then resume
      do_instr(2'b10, 1'b0, 1'b0, 8'h00, 8'h05, 0, 1'b0);
      do_instr(2'b00, 1'b0, 1'b0, 8'h00, 8'h00, 0, 1'b1);
      halt_req = 1'b1;
      imem_ack = 1'b1;
      repeat (2) @(negedge clk);
      imem_ack = 1'b0;
      halt_req = 1'b0;
      check("halt_hold_pc", pc, 8'h06);
      check("halt_hold", halted, 1);
      check("halt_no_req", imem_req, 0);
      do_start();
      check("resume_halted", halted, 0);
      do_instr(2'b10, 1'b0, 1'b0, 8'h00, 8'hFF, 0, 1'b0);
      do_instr(2'b00, 1'b0, 1'b0, 8'h00, 8'h00, 0, 1'b0);
      check("wrap_pc", pc, 8'h00);

      // Randomized instruction stream
      for (int i = 0; i < 40; i++) begin
         logic hr;
         hr = ($urandom_range(0, 9) == 0);
         do_instr(2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                  8'($urandom), 8'($urandom), $urandom_range(0, 3), hr);
         if (hr) do_start();
      end

      // Reset in the middle of a fetch wait
      imem_ack = 1'b0;
      @(negedge clk);
      check("midwait_req", imem_req, 1);
      rst_n = 1'b0;
      #1;
      m_pc = 8'h00; m_link = 8'h00; m_retired = 16'h0000;
      check("midrst_req", imem_req, 0);
      check("midrst_pc", pc, 0);
      check("midrst_busy", busy, 0);
      check("midrst_retired", retired, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_after_rst", busy, 0);
      do_start();

`ifdef FETCH_TIMEOUT_EN
      for (int i = 0; i < 15; i++) begin
         check("to_wait_busy", busy, 1);
         check("to_wait_fault", fault, 0);
         @(negedge clk);
      end
      check("to_fault", fault, 1);
      check("to_halted", halted, 1);
      check("to_req", imem_req, 0);
      do_start();
      @(negedge clk);
      check("to_start_ignored", halted, 1);
      check("to_start_no_req", imem_req, 0);
`else
      for (int i = 0; i < 100; i++) begin
         check("nto_fault", fault, 0);
         check("nto_req", imem_req, 1);
         @(negedge clk);
      end
      check("nto_addr", imem_addr, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Multi-cycle program-counter controller for the RISC CPU.
- Drives the instruction-memory fetch handshake and holds the PC register.
- Each instruction's branch-select field (BS), PS and Z flags are resolved into a 2-bit next-PC select using the same encoding as the datapath branch logic. The block then sequences the PC update, link save and pipeline flush.
- Sits between the control word decoder and the instruction memory.

Parameters:
- PC_W, 8, width of PC, jump target and link register.
- OFF_W, 8, width of the signed branch offset; sign-extended or truncated to PC_W.
- TO_W, 4, width of the fetch timeout counter (used only with FETCH_TIMEOUT_EN).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin or resume execution from IDLE or HALT.
- halt_req  in  1  stop after the current EXEC completes.
- imem_req  out  1  fetch request, held high until acknowledged.
- imem_addr  out  PC_W  fetch address, equals pc while imem_req=1.
- imem_ack  in  1  fetch complete; instruction valid this cycle.
- bs  in  2  branch select from the decoded control word.
- ps  in  1  branch polarity select.
- z  in  1  zero flag from the ALU.
- br_offset  in  OFF_W  signed PC-relative offset.
- jump_target  in  PC_W  absolute target, from register or immediate.
- pc  out  PC_W  current PC.
- link  out  PC_W  return address saved by call.
- pc_sel  out  2  resolved select, valid in EXEC; 0 otherwise.
- flush  out  1  one-cycle pulse when a non-sequential PC is taken.
- busy  out  1  high in FETCH and EXEC.
- halted  out  1  high in HALT.
- retired  out  16  count of retired instructions.
- fault  out  1  fetch timeout flag; tied 0 without FETCH_TIMEOUT_EN.

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE, and pc, link, retired=0. All other outputs are 0. Reset mid-fetch drops imem_req immediately.
- IDLE: start=1 -> FETCH on the next cycle. pc stays 0.
- FETCH:
  - imem_req=1 and imem_addr=pc.
  - imem_ack=1 -> EXEC on the next cycle. Zero-wait acknowledge is allowed, so a full instruction takes at least 2 cycles.
  - imem_ack=0 -> remain in FETCH.
  - imem_ack is ignored outside FETCH.
- EXEC (one cycle):
  - sel = {bs[1], bs[0] & (bs[1] | (ps ^ z))}.
  - sel 00: pc <= pc+1.
  - sel 01 (conditional branch taken): pc <= pc+1+sext(br_offset). Arithmetic is modulo 2^PC_W.
  - sel 10 (jump): pc <= jump_target.
  - sel 11 (call): pc <= jump_target, and link <= pc+1 (mod 2^PC_W).
  - flush=1 in this same cycle iff sel != 00.
  - retired increments by 1 and wraps at 0xFFFF.
  - Next state is HALT if halt_req=1 in this cycle, else FETCH. The PC update always completes first.
- HALT: halted=1, pc held. start=1 -> FETCH, resuming at pc. halt_req has no effect here.
- halt_req in FETCH is not latched; it is only sampled in EXEC.
- start outside IDLE and HALT is ignored.
- pc wrap-around: pc=2^PC_W-1 with sel 00 -> pc=0, with no error.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- When defined:
  - A TO_W-bit counter clears on entering FETCH and increments on each FETCH cycle with imem_ack=0.
  - Reaching 2^TO_W-1 without ack -> imem_req drops, fault <= 1, state -> HALT.
  - fault stays set until reset. start from HALT is ignored while fault=1.
- When undefined:
  - No counter is built, fault=0 constantly, and FETCH waits indefinitely.

Test Plan:
- Reset then start, imem_ack tied 1, bs=00 x3 -> pc sequence 0,1,2,3. retired=3, flush never high, one instruction every 2 cycles.
- Instruction at pc=0x10 with bs=01, ps=0, z=1, br_offset=0xFC -> pc=0x0D and flush pulse. Repeat with z=0 -> pc=0x11 and no flush.
- Instruction at pc=0x20 with bs=11, jump_target=0x80 -> pc=0x80, link=0x21, pc_sel=11. With bs=10 the same target is taken and link is unchanged.
- imem_ack delayed 3 cycles -> imem_req and imem_addr held stable for 4 cycles, EXEC follows exactly 1 cycle after ack. Assert rst_n=0 mid-wait -> pc=0, state IDLE, imem_req=0 immediately.
- halt_req=1 during EXEC with bs=00 at pc=0x05 -> pc=0x06 and halted=1. start -> fetch from 0x06. pc=0xFF with bs=00 -> pc=0x00.
- With FETCH_TIMEOUT_EN and TO_W=4, ack withheld -> fault=1 and halted=1 after 15 wait cycles, and a following start is ignored. Without the macro, fault stays 0 after 100 wait cycles.
